me_wr_pipe: RTL and testbench
=============================

Name: me_wr_pipe

Overview:
- Parametrised MEM/WB pipeline register for the five-stage CPU. Carries the memory read data, ALU result, destination register fields and writeback controls from stage 4 to stage 5.
- Adds the following over a plain register:
  - configurable depth;
  - valid tracking;
  - stall (hold) and flush (bubble insertion);
  - synchronous reset;
  - a pre-muxed writeback bus with a qualified write enable;
  - saturating stall and bubble performance counters.

Parameters:
- DW, 32: width of Do and ALUout data paths.
- AW, 5: width of rw/rd register-address fields.
- STAGES, 1: number of register stages between input and output; legal range 1..4.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- rst  in  1  synchronous active-high reset, sampled on the falling edge of clk.
- stall  in  1  hold all stages.
- flush  in  1  invalidate all stages.
- clr_cnt  in  1  synchronous clear of both counters.
- valid_4  in  1  stage-4 entry is a real instruction.
- Do_4  in  DW  memory read data.
- ALUout_4  in  DW  ALU result.
- rw_4  in  AW  write-register address.
- rd_4  in  AW  rd field.
- MemtoReg_4  in  1  writeback select.
- RegWr_4  in  1  register write request.
- valid_5  out  1  output entry valid.
- Do_5  out  DW  registered data.
- ALUout_5  out  DW  registered ALU result.
- rw_5  out  AW  registered write-register address.
- rd_5  out  AW  registered rd field.
- MemtoReg_5  out  1  registered writeback select.
- RegWr_5  out  1  registered write request.
- wb_data_5  out  DW  MemtoReg_5 ? Do_5 : ALUout_5 (combinational from registers).
- wb_en_5  out  1  RegWr_5 & valid_5 & (rw_5 != 0) (combinational).
- stage_valid  out  STAGES  valid bit of each stage; bit 0 is nearest the input.
- stall_cnt  out  CNT_W  count of stalled edges.
- bubble_cnt  out  CNT_W  count of bubbles inserted.

Behaviour:
- Reset (rst=1 at a falling edge):
  - All stage registers, including valid, Do, ALUout, rw, rd, MemtoReg and RegWr, go to 0.
  - stall_cnt and bubble_cnt go to 0.
  - Consequently every output reads 0 and wb_en_5=0.
  - rst overrides stall, flush and clr_cnt.
- Priority per falling edge: rst > flush > stall > normal shift.
- Normal shift (stall=0, flush=0):
  - Stage 0 loads the *_4 inputs, with valid = valid_4.
  - Stage k loads stage k-1.
  - Outputs are taken from stage STAGES-1.
  - Latency is STAGES falling edges; throughput is one entry per edge.
- Stall (stall=1, flush=0): all stages hold their contents unchanged; the stage-4 inputs are ignored.
- Flush (flush=1):
  - Every stage valid goes to 0, and RegWr and MemtoReg in every stage go to 0.
  - The data and address fields of every stage go to 0.
  - The input presented on that edge is discarded.
  - A simultaneous stall is ignored.
- Invalid entry (valid_4=0): the entry shifts normally. RegWr is stored as RegWr_4 & valid_4, so a bubble never carries a write request.
- wb_en_5: never asserts for rw_5=0; register $0 writes are suppressed here.
- Counters (saturating, both frozen at all-ones; no wrap):
  - stall_cnt += 1 on any edge with rst=0, flush=0, stall=1, clr_cnt=0.
  - bubble_cnt += 1 on any edge with rst=0, clr_cnt=0, and either (flush=1) or (stall=0 and valid_4=0).
  - clr_cnt=1 (rst=0) zeroes both counters on that edge and suppresses their increment; pipeline behaviour on that edge is unaffected.
- Reset asserted mid-stream: in-flight entries are lost. The first post-reset capture is the edge after rst deasserts.
- STAGES outside 1..4: elaboration-time error.

Test Plan:
- Reset, STAGES=1: hold rst=1 for 2 edges with Do_4=32'hDEADBEEF, RegWr_4=1, valid_4=1 -> all outputs 0, wb_en_5=0, both counters 0.
- Shift, STAGES=3: after reset, apply valid_4=1, ALUout_4=32'h11, 32'h22, 32'h33, RegWr_4=1, MemtoReg_4=0, rw_4=5'd8 on consecutive edges -> ALUout_5 = 32'h11 after the 3rd edge, then 32'h22 and 32'h33 on the following edges; wb_data_5 equals ALUout_5 and wb_en_5=1 throughout; stage_valid=3'b111.
- Stall, STAGES=1: entry ALUout=32'h55 loaded; stall=1 for 4 edges while ALUout_4=32'h66 -> ALUout_5 stays 32'h55 and stall_cnt=4; after stall drops, 32'h66 appears on the next edge.
- Flush+stall, STAGES=2: with both stages valid, assert flush=1 and stall=1 together -> stage_valid=2'b00, RegWr_5=0, wb_en_5=0, bubble_cnt += 1, stall_cnt unchanged.
- Writeback mux/$0: MemtoReg_4=1, Do_4=32'hA5A5A5A5, rw_4=0, RegWr_4=1, valid_4=1 -> wb_data_5=32'hA5A5A5A5 and wb_en_5=0; repeat with rw_4=5'd3 -> wb_en_5=1.
- Counter saturation/clear, CNT_W=4: hold valid_4=0 for 20 edges -> bubble_cnt saturates at 4'hF; pulse clr_cnt -> both counters 0 on that edge, and counting resumes on the next edge.

Source files
------------

// File: rtl/me_wr_pipe.sv
// MEM/WB pipeline register: configurable depth, valid tracking, stall/flush,
// pre-muxed writeback bus and saturating stall/bubble counters (falling-edge state).
module me_wr_pipe #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              valid_4,
    input  logic [DW-1:0]     Do_4,
    input  logic [DW-1:0]     ALUout_4,
    input  logic [AW-1:0]     rw_4,
    input  logic [AW-1:0]     rd_4,
    input  logic              MemtoReg_4,
    input  logic              RegWr_4,
    output logic              valid_5,
    output logic [DW-1:0]     Do_5,
    output logic [DW-1:0]     ALUout_5,
    output logic [AW-1:0]     rw_5,
    output logic [AW-1:0]     rd_5,
    output logic              MemtoReg_5,
    output logic              RegWr_5,
    output logic [DW-1:0]     wb_data_5,
    output logic              wb_en_5,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("me_wr_pipe: STAGES must be in 1..4");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] m2r_r;
    logic [STAGES-1:0] regwr_r;
    logic [DW-1:0]     do_r  [STAGES];
    logic [DW-1:0]     alu_r [STAGES];
    logic [AW-1:0]     rw_r  [STAGES];
    logic [AW-1:0]     rd_r  [STAGES];
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic              stall_inc_s;
    logic              bubble_inc_s;

    // Stage registers: reset and flush clear everything, stall holds, otherwise shift.
    always_ff @(negedge clk) begin
        if (rst || flush) begin
            valid_r <= {STAGES{1'b0}};
            m2r_r   <= {STAGES{1'b0}};
            regwr_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                do_r[k]  <= {DW{1'b0}};
                alu_r[k] <= {DW{1'b0}};
                rw_r[k]  <= {AW{1'b0}};
                rd_r[k]  <= {AW{1'b0}};
            end
        end else if (!stall) begin
            // A bubble must never carry a write request downstream.
            valid_r[0] <= valid_4;
            m2r_r[0]   <= MemtoReg_4;
            regwr_r[0] <= RegWr_4 & valid_4;
            do_r[0]    <= Do_4;
            alu_r[0]   <= ALUout_4;
            rw_r[0]    <= rw_4;
            rd_r[0]    <= rd_4;
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                m2r_r[k]   <= m2r_r[k-1];
                regwr_r[k] <= regwr_r[k-1];
                do_r[k]    <= do_r[k-1];
                alu_r[k]   <= alu_r[k-1];
                rw_r[k]    <= rw_r[k-1];
                rd_r[k]    <= rd_r[k-1];
            end
        end
    end

    // Counter increment qualifiers: flush outranks stall, and a flush is itself a bubble.
    always_comb begin
        stall_inc_s  = 1'b0;
        bubble_inc_s = 1'b0;
        if (flush) begin
            bubble_inc_s = 1'b1;
        end else begin
            stall_inc_s  = stall;
            bubble_inc_s = ~stall & ~valid_4;
        end
    end

    // Saturating performance counters with synchronous clear.
    always_ff @(negedge clk) begin
        if (rst || clr_cnt) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (bubble_inc_s && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end
        end
    end

    assign valid_5     = valid_r[STAGES-1];
    assign Do_5        = do_r[STAGES-1];
    assign ALUout_5    = alu_r[STAGES-1];
    assign rw_5        = rw_r[STAGES-1];
    assign rd_5        = rd_r[STAGES-1];
    assign MemtoReg_5  = m2r_r[STAGES-1];
    assign RegWr_5     = regwr_r[STAGES-1];
    assign stage_valid = valid_r;
    assign stall_cnt   = stall_cnt_r;
    assign bubble_cnt  = bubble_cnt_r;

    // Writes to register $0 are dropped here so the register file need not care.
    assign wb_data_5 = MemtoReg_5 ? Do_5 : ALUout_5;
    assign wb_en_5   = RegWr_5 & valid_5 & (rw_5 != {AW{1'b0}});

endmodule

// File: tb/tb_me_wr_pipe.sv
// Directed bench for me_wr_pipe: three instances (depth 1 with 4-bit counters,
// depth 2, depth 3) share one stimulus stream and are checked against hand values.
module tb_me_wr_pipe;

    logic        clk = 1'b1;
    logic        rst, stall, flush, clr_cnt, valid_4, MemtoReg_4, RegWr_4;
    logic [31:0] Do_4, ALUout_4;
    logic [4:0]  rw_4, rd_4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic        a_valid, a_m2r, a_rwr, a_wbe;
    logic [31:0] a_do, a_alu, a_wbd;
    logic [4:0]  a_rw, a_rd;
    logic [0:0]  a_sv;
    logic [3:0]  a_sc, a_bc;

    logic        b_valid, b_m2r, b_rwr, b_wbe;
    logic [31:0] b_do, b_alu, b_wbd;
    logic [4:0]  b_rw, b_rd;
    logic [1:0]  b_sv;
    logic [15:0] b_sc, b_bc;

    logic        c_valid, c_m2r, c_rwr, c_wbe;
    logic [31:0] c_do, c_alu, c_wbd;
    logic [4:0]  c_rw, c_rd;
    logic [2:0]  c_sv;
    logic [15:0] c_sc, c_bc;

    me_wr_pipe #(.DW(32), .AW(5), .STAGES(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .valid_4(valid_4), .Do_4(Do_4), .ALUout_4(ALUout_4), .rw_4(rw_4), .rd_4(rd_4),
        .MemtoReg_4(MemtoReg_4), .RegWr_4(RegWr_4),
        .valid_5(a_valid), .Do_5(a_do), .ALUout_5(a_alu), .rw_5(a_rw), .rd_5(a_rd),
        .MemtoReg_5(a_m2r), .RegWr_5(a_rwr), .wb_data_5(a_wbd), .wb_en_5(a_wbe),
        .stage_valid(a_sv), .stall_cnt(a_sc), .bubble_cnt(a_bc)
    );

    me_wr_pipe #(.DW(32), .AW(5), .STAGES(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .valid_4(valid_4), .Do_4(Do_4), .ALUout_4(ALUout_4), .rw_4(rw_4), .rd_4(rd_4),
        .MemtoReg_4(MemtoReg_4), .RegWr_4(RegWr_4),
        .valid_5(b_valid), .Do_5(b_do), .ALUout_5(b_alu), .rw_5(b_rw), .rd_5(b_rd),
        .MemtoReg_5(b_m2r), .RegWr_5(b_rwr), .wb_data_5(b_wbd), .wb_en_5(b_wbe),
        .stage_valid(b_sv), .stall_cnt(b_sc), .bubble_cnt(b_bc)
    );

    me_wr_pipe #(.DW(32), .AW(5), .STAGES(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .valid_4(valid_4), .Do_4(Do_4), .ALUout_4(ALUout_4), .rw_4(rw_4), .rd_4(rd_4),
        .MemtoReg_4(MemtoReg_4), .RegWr_4(RegWr_4),
        .valid_5(c_valid), .Do_5(c_do), .ALUout_5(c_alu), .rw_5(c_rw), .rd_5(c_rd),
        .MemtoReg_5(c_m2r), .RegWr_5(c_rwr), .wb_data_5(c_wbd), .wb_en_5(c_wbe),
        .stage_valid(c_sv), .stall_cnt(c_sc), .bubble_cnt(c_bc)
    );

    // One active (falling) edge, then sample on the following rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        valid_4 = 1'b1; Do_4 = 32'hDEADBEEF; ALUout_4 = 32'h0;
        rw_4 = 5'd8; rd_4 = 5'd9; MemtoReg_4 = 1'b0; RegWr_4 = 1'b1;

        // Reset held for two edges
        tick(); tick();
        chk("rst_valid", {63'd0, a_valid}, 64'd0);
        chk("rst_do", {32'd0, a_do}, 64'd0);
        chk("rst_rwr", {63'd0, a_rwr}, 64'd0);
        chk("rst_rw", {59'd0, a_rw}, 64'd0);
        chk("rst_wbd", {32'd0, a_wbd}, 64'd0);
        chk("rst_wbe", {63'd0, a_wbe}, 64'd0);
        chk("rst_cnts", {56'd0, a_sc, a_bc}, 64'd0);
        chk("rst_sv3", {61'd0, c_sv}, 64'd0);

        // Shift through the depth-3 instance
        rst = 1'b0; Do_4 = 32'h0;
        ALUout_4 = 32'h11; tick();
        chk("sh_sv1", {61'd0, c_sv}, 64'd1);
        chk("sh_alu_lat", {32'd0, c_alu}, 64'd0);
        ALUout_4 = 32'h22; tick();
        chk("sh_sv2", {61'd0, c_sv}, 64'd3);
        ALUout_4 = 32'h33; tick();
        chk("sh_alu_11", {32'd0, c_alu}, 64'h11);
        chk("sh_wbd_11", {32'd0, c_wbd}, 64'h11);
        chk("sh_wbe_11", {63'd0, c_wbe}, 64'd1);
        chk("sh_sv7", {61'd0, c_sv}, 64'd7);
        chk("sh_rw", {59'd0, c_rw}, 64'd8);
        chk("sh_rd", {59'd0, c_rd}, 64'd9);
        ALUout_4 = 32'h44; tick();
        chk("sh_alu_22", {32'd0, c_alu}, 64'h22);
        chk("sh_wbe_22", {63'd0, c_wbe}, 64'd1);
        ALUout_4 = 32'h55; tick();
        chk("sh_alu_33", {32'd0, c_alu}, 64'h33);
        chk("sh_wbd_33", {32'd0, c_wbd}, 64'h33);
        chk("ld_alu_55", {32'd0, a_alu}, 64'h55);
        chk("no_bubbles", {60'd0, a_bc}, 64'd0);

        // Stall four edges while a new value waits at the input
        stall = 1'b1; ALUout_4 = 32'h66;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_hold", {32'd0, a_alu}, 64'h55);
        end
        chk("st_cnt1", {60'd0, a_sc}, 64'd4);
        chk("st_cnt2", {48'd0, b_sc}, 64'd4);
        chk("st_hold2", {32'd0, b_alu}, 64'h44);
        stall = 1'b0; tick();
        chk("st_release", {32'd0, a_alu}, 64'h66);
        chk("st_release2", {32'd0, b_alu}, 64'h55);
        chk("st_sv2", {62'd0, b_sv}, 64'd3);

        // Flush with simultaneous stall
        flush = 1'b1; stall = 1'b1; ALUout_4 = 32'h77; tick();
        chk("fl_sv", {62'd0, b_sv}, 64'd0);
        chk("fl_rwr", {63'd0, b_rwr}, 64'd0);
        chk("fl_wbe", {63'd0, b_wbe}, 64'd0);
        chk("fl_alu", {32'd0, b_alu}, 64'd0);
        chk("fl_rw", {59'd0, b_rw}, 64'd0);
        chk("fl_bub", {48'd0, b_bc}, 64'd1);
        chk("fl_stc", {48'd0, b_sc}, 64'd4);
        chk("fl_sv3", {61'd0, c_sv}, 64'd0);

        // Writeback mux and $0 suppression
        flush = 1'b0; stall = 1'b0;
        MemtoReg_4 = 1'b1; Do_4 = 32'hA5A5A5A5; ALUout_4 = 32'h12345678; rw_4 = 5'd0;
        tick();
        chk("wb0_data", {32'd0, a_wbd}, 64'hA5A5A5A5);
        chk("wb0_en", {63'd0, a_wbe}, 64'd0);
        chk("wb0_rwr", {63'd0, a_rwr}, 64'd1);
        rw_4 = 5'd3; Do_4 = 32'h5A5A5A5A; tick();
        chk("wb3_en", {63'd0, a_wbe}, 64'd1);
        chk("wb3_data", {32'd0, a_wbd}, 64'h5A5A5A5A);
        chk("wb3_rw", {59'd0, a_rw}, 64'd3);
        chk("wb0_data2", {32'd0, b_wbd}, 64'hA5A5A5A5);
        chk("wb0_en2", {63'd0, b_wbe}, 64'd0);

        // Invalid entries: no write request, bubbles counted, 4-bit counter saturates
        valid_4 = 1'b0; tick();
        chk("inv_valid", {63'd0, a_valid}, 64'd0);
        chk("inv_rwr", {63'd0, a_rwr}, 64'd0);
        chk("inv_wbe", {63'd0, a_wbe}, 64'd0);
        chk("inv_m2r", {63'd0, a_m2r}, 64'd1);
        chk("inv_bub", {60'd0, a_bc}, 64'd2);
        for (int i = 0; i < 19; i++) tick();
        chk("sat_bub1", {60'd0, a_bc}, 64'hF);
        chk("bub2", {48'd0, b_bc}, 64'd21);
        clr_cnt = 1'b1; tick();
        chk("clr_bub", {60'd0, a_bc}, 64'd0);
        chk("clr_stc", {60'd0, a_sc}, 64'd0);
        chk("clr_bub2", {48'd0, b_bc}, 64'd0);
        clr_cnt = 1'b0; tick();
        chk("resume_bub", {60'd0, a_bc}, 64'd1);
        chk("resume_bub2", {48'd0, b_bc}, 64'd1);

        // Reset mid-stream drops in-flight entries
        valid_4 = 1'b1; MemtoReg_4 = 1'b0; ALUout_4 = 32'h88; tick();
        chk("pre_rst_sv", {61'd0, c_sv}, 64'd1);
        rst = 1'b1; stall = 1'b1; tick();
        chk("mid_rst_sv", {61'd0, c_sv}, 64'd0);
        chk("mid_rst_cnt", {60'd0, a_bc}, 64'd0);
        rst = 1'b0; stall = 1'b0; ALUout_4 = 32'h99; tick();
        chk("post_rst_alu", {32'd0, a_alu}, 64'h99);
        chk("post_rst_sv", {61'd0, c_sv}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
